match_sequencer: RTL and testbench

//  Sequences one match of the volleyball game. Generates the 60 Hz frame tick and runs the

---
 rtl/match_pkg.sv | 21 ++
 rtl/frame_tick_gen.sv | 22 ++
 rtl/match_sequencer.sv | 156 +++++++++++++++
 tb/tb_match_sequencer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/match_pkg.sv
// Shared state encoding, target-score table and helpers for the match sequencer.
package match_pkg;

   typedef enum logic [2:0] {
      ST_READY = 3'd0,
      ST_SERVE = 3'd1,
      ST_RALLY = 3'd2,
      ST_HOLD  = 3'd3,
      ST_OVER  = 3'd4
   } state_t;

   localparam int MODE_W = 2;
   localparam logic [MODE_W-1:0] MODE_MAX = 2'd3;

   localparam logic [3:0] WIN_SCORE [4] = '{4'd3, 4'd5, 4'd7, 4'd9};

   function automatic logic [3:0] win_of(input logic [MODE_W-1:0] mode);
      return WIN_SCORE[mode];
   endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Free-running frame divider: one-cycle tick every FRAME_DIV clocks.
module frame_tick_gen #(
   parameter int FRAME_DIV = 1666666
) (
   input  logic clk,
   input  logic reset_n,
   output logic tick
);

   localparam int CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

   logic [CNT_W-1:0] cnt;

   assign tick = (cnt == CNT_W'(FRAME_DIV - 1));

   always_ff @(posedge clk) begin
      if (!reset_n)  cnt <= '0;
      else if (tick) cnt <= '0;
      else           cnt <= cnt + CNT_W'(1);
   end

endmodule

// File: rtl/match_sequencer.sv
// Match FSM: frame pacing, physics handshake, scoring and serve selection.
// Optional PAUSE_EN adds pause_sw, which freezes rally stepping and hold counting.
module match_sequencer
   import match_pkg::*;
#(
   parameter int FRAME_DIV   = 1666666,
   parameter int HOLD_FRAMES = 60,
   parameter int SCORE_W     = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start_sw,
   input  logic               mode_up,
   input  logic               mode_down,
   input  logic               phys_valid,
   input  logic               phys_point,
   input  logic [1:0]         phys_winner,
`ifdef PAUSE_EN
   input  logic               pause_sw,
`endif
   output logic               phys_en,
   output logic               rally_rst,
   output logic               serve_side,
   output logic               latch_en,
   output logic [SCORE_W-1:0] p1_score,
   output logic [SCORE_W-1:0] p2_score,
   output logic [SCORE_W-1:0] win_score,
   output logic [2:0]         state_o,
   output logic [7:0]         overrun_cnt
);

   localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

   state_t              state;
   logic [MODE_W-1:0]   mode;
   logic [HOLD_W-1:0]   hold_cnt;
   logic                pending;
   logic                start_q;
   logic                start_edge;
   logic                tick;
   logic                paused;
   logic                step_done;
   logic                point_hit;
   logic [SCORE_W-1:0]  p1_nxt;
   logic [SCORE_W-1:0]  p2_nxt;
   logic [SCORE_W-1:0]  pt_score;

   frame_tick_gen #(.FRAME_DIV(FRAME_DIV)) u_tick (
      .clk     (clk),
      .reset_n (reset_n),
      .tick    (tick)
   );

`ifdef PAUSE_EN
   assign paused = pause_sw;
`else
   assign paused = 1'b0;
`endif

   // Sampled through reset too, so a switch left high never looks like an edge.
   always_ff @(posedge clk) start_q <= start_sw;

   assign start_edge = (start_sw != start_q);
   assign win_score  = SCORE_W'(win_of(mode));
   assign state_o    = state;

   always_comb begin
      step_done = phys_valid && pending;
      point_hit = step_done && phys_point && (phys_winner == 2'd1 || phys_winner == 2'd2);
      p1_nxt    = (p1_score == '1) ? p1_score : p1_score + SCORE_W'(1);
      p2_nxt    = (p2_score == '1) ? p2_score : p2_score + SCORE_W'(1);
      pt_score  = (phys_winner == 2'd1) ? p1_nxt : p2_nxt;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= ST_READY;
         mode        <= '0;
         hold_cnt    <= '0;
         pending     <= 1'b0;
         phys_en     <= 1'b0;
         rally_rst   <= 1'b0;
         serve_side  <= 1'b0;
         latch_en    <= 1'b0;
         p1_score    <= '0;
         p2_score    <= '0;
         overrun_cnt <= '0;
      end else begin
         phys_en  <= 1'b0;
         latch_en <= 1'b0;
         case (state)
            ST_READY: begin
               if (mode_up && !mode_down && mode != MODE_MAX)
                  mode <= mode + MODE_W'(1);
               else if (mode_down && !mode_up && mode != '0)
                  mode <= mode - MODE_W'(1);
               if (start_edge) begin
                  p1_score   <= '0;
                  p2_score   <= '0;
                  serve_side <= 1'b0;
                  rally_rst  <= 1'b1;
                  pending    <= 1'b0;
                  state      <= ST_SERVE;
               end
            end
            ST_SERVE: begin
               if (tick) begin
                  rally_rst <= 1'b0;
                  state     <= ST_RALLY;
               end
            end
            ST_RALLY: begin
               if (step_done) begin
                  pending  <= 1'b0;
                  latch_en <= 1'b1;
               end
               if (point_hit) begin
                  if (phys_winner == 2'd1) begin
                     p1_score   <= p1_nxt;
                     serve_side <= 1'b0;
                  end else begin
                     p2_score   <= p2_nxt;
                     serve_side <= 1'b1;
                  end
                  if (pt_score == win_score) begin
                     state <= ST_OVER;
                  end else begin
                     state     <= ST_HOLD;
                     rally_rst <= 1'b1;
                     hold_cnt  <= '0;
                  end
               end else if (tick && !paused) begin
                  // A frame arriving while physics is still busy is dropped, not queued.
                  if (!pending) begin
                     phys_en <= 1'b1;
                     pending <= 1'b1;
                  end else if (overrun_cnt != 8'hFF) begin
                     overrun_cnt <= overrun_cnt + 8'd1;
                  end
               end
            end
            ST_HOLD: begin
               if (tick && !paused) begin
                  if (hold_cnt == HOLD_W'(HOLD_FRAMES - 1)) state <= ST_SERVE;
                  else hold_cnt <= hold_cnt + HOLD_W'(1);
               end
            end
            ST_OVER: begin
               if (start_edge) state <= ST_READY;
            end
            default: state <= ST_READY;
         endcase
      end
   end

endmodule

// File: tb/tb_match_sequencer.sv
// Self-checking bench for match_sequencer: directed scenarios plus a randomized match,
// all against a frame/score reference model. Define PAUSE_EN to cover pause_sw.
module tb_match_sequencer;

   localparam int FDIV = 10;
   localparam int HFR  = 2;
   localparam int SW   = 4;
   localparam logic [26:0] RST_VEC = 27'(3) << 11;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          start_sw = 1'b0;
   logic          mode_up = 1'b0;
   logic          mode_down = 1'b0;
   logic          phys_valid = 1'b0;
   logic          phys_point = 1'b0;
   logic [1:0]    phys_winner = 2'd0;
   logic          pause_sw = 1'b0;
   logic          phys_en, rally_rst, serve_side, latch_en;
   logic [SW-1:0] p1_score, p2_score, win_score;
   logic [2:0]    state_o;
   logic [7:0]    overrun_cnt;

   int n_chk = 0;
   int n_err = 0;

   // reference model state
   int m_fcnt = 0, m_st = 0, m_idx = 0, m_serve = 0, m_rst = 0, m_pend = 0;
   int m_left = 0, m_ovr = 0, m_pe = 0, m_le = 0;
   int m_score [3] = '{0, 0, 0};
   bit m_sprev = 1'b0;
   int targets [4] = '{3, 5, 7, 9};

   // physics responder
   bit rsp_en = 1'b1, rsp_arm = 1'b0, rsp_point = 1'b0, rnd_mode = 1'b0;
   int rsp_cd = 0, rsp_lat = 3;
   logic [1:0] rsp_win = 2'd0;

   always #5 clk = ~clk;

   match_sequencer #(.FRAME_DIV(FDIV), .HOLD_FRAMES(HFR), .SCORE_W(SW)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start_sw    (start_sw),
      .mode_up     (mode_up),
      .mode_down   (mode_down),
      .phys_valid  (phys_valid),
      .phys_point  (phys_point),
      .phys_winner (phys_winner),
`ifdef PAUSE_EN
      .pause_sw    (pause_sw),
`endif
      .phys_en     (phys_en),
      .rally_rst   (rally_rst),
      .serve_side  (serve_side),
      .latch_en    (latch_en),
      .p1_score    (p1_score),
      .p2_score    (p2_score),
      .win_score   (win_score),
      .state_o     (state_o),
      .overrun_cnt (overrun_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [26:0] dut_vec();
      return {phys_en, rally_rst, serve_side, latch_en, p1_score, p2_score,
              win_score, state_o, overrun_cnt};
   endfunction

   function automatic logic [26:0] mod_vec();
      return {1'(m_pe), 1'(m_rst), 1'(m_serve), 1'(m_le), SW'(m_score[1]), SW'(m_score[2]),
              SW'(targets[m_idx]), 3'(m_st), 8'(m_ovr)};
   endfunction

   // One clock of the match rules, applied to the inputs present at the edge.
   task automatic model_step();
      bit tk, edg, pz, fin;
      int w;
      tk = (m_fcnt == FDIV - 1);
      m_fcnt = tk ? 0 : m_fcnt + 1;
      edg = (start_sw != m_sprev);
      m_sprev = start_sw;
      m_pe = 0;
      m_le = 0;
`ifdef PAUSE_EN
      pz = pause_sw;
`else
      pz = 1'b0;
`endif
      if (!reset_n) begin
         m_fcnt = 0; m_st = 0; m_idx = 0; m_score = '{0, 0, 0};
         m_serve = 0; m_rst = 0; m_pend = 0; m_ovr = 0;
         return;
      end
      case (m_st)
         0: begin
            if (mode_up && !mode_down && m_idx < 3) m_idx++;
            if (mode_down && !mode_up && m_idx > 0) m_idx--;
            if (edg) begin
               m_score[1] = 0; m_score[2] = 0; m_serve = 0; m_rst = 1; m_pend = 0; m_st = 1;
            end
         end
         1: if (tk) begin m_rst = 0; m_st = 2; end
         2: begin
            w = int'(phys_winner);
            fin = phys_valid && (m_pend != 0);
            if (fin && phys_point && (w == 1 || w == 2)) begin
               m_pend = 0; m_le = 1;
               if (m_score[w] < 15) m_score[w]++;
               m_serve = w - 1;
               if (m_score[w] == targets[m_idx]) m_st = 4;
               else begin m_st = 3; m_rst = 1; m_left = HFR; end
            end else begin
               if (tk && !pz) begin
                  if (m_pend != 0) m_ovr = (m_ovr < 255) ? m_ovr + 1 : 255;
                  else m_pe = 1;
               end
               if (fin) begin m_pend = 0; m_le = 1; end
               else if (m_pe != 0) m_pend = 1;
            end
         end
         3: if (tk && !pz) begin
            m_left--;
            if (m_left == 0) m_st = 1;
         end
         4: if (edg) m_st = 0;
         default: m_st = 0;
      endcase
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
      chk("outs", 32'(dut_vec()), 32'(mod_vec()));
      mode_up = 1'b0; mode_down = 1'b0;
      phys_valid = 1'b0; phys_point = 1'b0; phys_winner = 2'd0;
      if (rsp_cd > 0) rsp_cd--;
      if (rsp_arm && rsp_cd == 0 && rsp_en) begin
         rsp_arm = 1'b0;
         phys_valid = 1'b1;
         if (rnd_mode) begin
            phys_point  = ($urandom_range(0, 2) == 0);
            phys_winner = 2'($urandom_range(0, 3));
         end else begin
            phys_point  = rsp_point;
            phys_winner = rsp_win;
         end
      end
      if (phys_en === 1'b1) begin
         rsp_arm = 1'b1;
         rsp_cd  = rnd_mode ? int'($urandom_range(1, 14)) : rsp_lat;
      end
   endtask

   task automatic wait_st(input int st, input int budget);
      int n = 0;
      while (state_o !== 3'(st) && n < budget) begin cyc(); n++; end
      chk("wait_st", 32'(state_o), 32'(st));
   endtask

   task automatic wait_pe(input int budget);
      int n = 0;
      while (phys_en !== 1'b1 && n < budget) begin cyc(); n++; end
      chk("wait_pe", 32'(phys_en), 32'd1);
   endtask

   task automatic wait_latch(input int budget);
      int n = 0;
      while (latch_en !== 1'b1 && n < budget) begin cyc(); n++; end
      chk("wait_latch", 32'(latch_en), 32'd1);
   endtask

   initial begin
      int cnt;
      int up_exp [5] = '{5, 7, 9, 9, 9};
      int dn_exp [4] = '{7, 5, 3, 3};

      // reset
      cyc(); cyc();
      reset_n = 1'b1;
      chk("rst_vec", 32'(dut_vec()), 32'(RST_VEC));

      // target score stepping
      for (int i = 0; i < 5; i++) begin
         mode_up = 1'b1; cyc();
         chk("mode_up", 32'(win_score), 32'(up_exp[i]));
      end
      mode_up = 1'b1; mode_down = 1'b1; cyc();
      chk("mode_both", 32'(win_score), 32'd9);
      for (int i = 0; i < 4; i++) begin
         mode_down = 1'b1; cyc();
         chk("mode_down", 32'(win_score), 32'(dn_exp[i]));
      end

      // start, one step per frame, latch one cycle after valid
      start_sw = ~start_sw; cyc();
      chk("serve_st", 32'(state_o), 32'd1);
      chk("serve_rst", 32'(rally_rst), 32'd1);
      wait_st(2, 40);
      cnt = 0;
      repeat (50) begin cyc(); cnt += int'(phys_en); end
      chk("pe_per_tick", 32'(cnt), 32'd5);
      wait_pe(20);
      cnt = 0;
      while (latch_en !== 1'b1 && cnt < 20) begin cyc(); cnt++; end
      chk("latch_lat", 32'(cnt), 32'd4);

      // physics busy across two frames
      rsp_en = 1'b0;
      wait_pe(20);
      cnt = 0;
      repeat (25) begin cyc(); cnt += int'(phys_en); end
      chk("no_2nd_pe", 32'(cnt), 32'd0);
      chk("overrun", 32'(overrun_cnt), 32'd2);
      rsp_en = 1'b1;
      wait_latch(20);

      // P2 point, hold, re-serve; winner 3 ignored
      rsp_point = 1'b1; rsp_win = 2'd2;
      wait_st(3, 40);
      chk("p2_pt", 32'({p1_score, p2_score}), 32'h01);
      chk("serve_p2", 32'(serve_side), 32'd1);
      chk("hold_rst", 32'(rally_rst), 32'd1);
      rsp_point = 1'b0;
      wait_st(2, 80);
      chk("rally_rst_off", 32'(rally_rst), 32'd0);
      rsp_point = 1'b1; rsp_win = 2'd3;
      wait_pe(20);
      wait_latch(20);
      chk("w3_ignored", 32'({p1_score, p2_score}), 32'h01);
      chk("w3_state", 32'(state_o), 32'd2);

      // P1 takes the match at 3
      rsp_win = 2'd1;
      wait_st(4, 400);
      chk("p1_final", 32'({p1_score, p2_score}), 32'h31);
      chk("serve_p1", 32'(serve_side), 32'd0);
      rsp_point = 1'b0;
      cnt = 0;
      repeat (100) begin cyc(); cnt += int'(phys_en); end
      chk("over_no_pe", 32'(cnt), 32'd0);
      start_sw = ~start_sw; cyc();
      chk("over_ready", 32'(state_o), 32'd0);
      chk("score_kept", 32'({p1_score, p2_score}), 32'h31);

      // randomized matches
      rnd_mode = 1'b1;
      repeat (3000) begin
         if ($urandom_range(0, 15) == 0) mode_up = 1'b1;
         if ($urandom_range(0, 15) == 0) mode_down = 1'b1;
         if ((state_o == 3'd0 || state_o == 3'd4) && $urandom_range(0, 19) == 0)
            start_sw = ~start_sw;
         cyc();
      end
      rnd_mode = 1'b0;

      // reset in the middle of a rally
      reset_n = 1'b0; cyc(); reset_n = 1'b1;
      start_sw = ~start_sw; cyc();
      wait_st(2, 40);
      repeat (3) cyc();
      reset_n = 1'b0; cyc();
      chk("mid_rst", 32'(dut_vec()), 32'(RST_VEC));
      reset_n = 1'b1;
      cnt = 0;
      repeat (30) begin cyc(); cnt += int'(phys_en); end
      chk("rst_no_pe", 32'(cnt), 32'd0);

`ifdef PAUSE_EN
      start_sw = ~start_sw; cyc();
      wait_st(2, 40);
      wait_pe(20);
      wait_latch(20);
      pause_sw = 1'b1;
      cnt = 0;
      repeat (50) begin cyc(); cnt += int'(phys_en); end
      chk("pause_no_pe", 32'(cnt), 32'd0);
      pause_sw = 1'b0;
      wait_pe(20);
`endif

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
